lcd_spi_byte_tx: RTL

Downstream SPI transmit engine for the ST77xx-style LCD path. It accepts 9-bit entries {dc, byte} from the command/pixel sequencer into a small FIFO and serialises them as SPI mode 0, MSB first. It drives cs_n, scl, sda and dc, holding cs_n low across back-to-back entries so pixel streams are not broken. It reports per-byte completion and FIFO status back to the sequencer.

---
 rtl/lcd_spi_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/lcd_spi_byte_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_spi_pkg.sv
// Shared types and constants for the ST77xx SPI transmit path.
package lcd_spi_pkg;

   // Transmit FSM states.
   typedef enum logic [2:0] {
      StIdle,
      StLow,
      StHigh,
      StHold,
      StGap
   } spi_state_e;

   // FIFO entry is {dc, byte}.
   localparam int unsigned ENTRY_W = 9;

   // D/C line levels.
   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   // ST77xx opcodes and arguments used by the sequencer.
   localparam logic [7:0] SLPOUT       = 8'h11;
   localparam logic [7:0] DISPON       = 8'h29;
   localparam logic [7:0] COLMOD       = 8'h3A;
   localparam logic [7:0] RAMWR        = 8'h2C;
   localparam logic [7:0] COLMOD_16BPP = 8'h55;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead head entry and registered full/empty flags.
module sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push, pop;

   // Writes while full are dropped even if a pop happens in the same cycle.
   assign push = wr_en && !full_q;
   assign pop  = rd_en && !empty_q;

   // Pointer, occupancy and flag next-state; pointers wrap because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_FULL);
      empty_d = (count_d == '0);
   end

   // Pointer and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage array; no reset needed since reads are gated by empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign full    = full_q;
   assign empty   = empty_q;

endmodule

// File: rtl/lcd_spi_byte_tx.sv
// SPI mode-0 byte transmitter for ST77xx LCDs: FIFO of {dc, byte}, MSB first,
// cs_n held low across back-to-back entries.
module lcd_spi_byte_tx
   import lcd_spi_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   input  logic          wr_dc,
   input  logic [PW-1:0] prescaler,
   output logic          full,
   output logic          empty,
   output logic          overflow,
   output logic          byte_done,
   output logic          busy,
   output logic          cs_n,
   output logic          scl,
   output logic          sda,
   output logic          dc
);

   spi_state_e           state_q, state_d;
   logic [PW-1:0]        cnt_q, cnt_d;
   logic [PW-1:0]        pre_q, pre_d;
   logic [2:0]           bitcnt_q, bitcnt_d;
   logic [7:0]           shift_q, shift_d;
   logic                 cs_n_q, cs_n_d;
   logic                 scl_q, scl_d;
   logic                 sda_q, sda_d;
   logic                 dc_q, dc_d;
   logic                 busy_q, busy_d;
   logic                 byte_done_q, byte_done_d;
   logic                 overflow_q, overflow_d;
   logic                 pop;
   logic                 phase_end;
   logic [ENTRY_W-1:0]   head;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data ({wr_dc, wr_data}),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   // Each LOW/HIGH/HOLD/GAP phase lasts pre_q+1 cycles.
   assign phase_end = (cnt_q == pre_q);

   // Next-state and output logic for the transmit FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + PW'(1);
      pre_d       = pre_q;
      bitcnt_d    = bitcnt_q;
      shift_d     = shift_q;
      cs_n_d      = cs_n_q;
      scl_d       = scl_q;
      sda_d       = sda_q;
      dc_d        = dc_q;
      busy_d      = busy_q;
      byte_done_d = 1'b0;
      overflow_d  = wr_en && full;
      pop         = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d  = '0;
            cs_n_d = 1'b1;
            scl_d  = 1'b0;
            // Prescaler is frozen for the whole frame from here on.
            pre_d  = prescaler;
            if (!empty) begin
               pop      = 1'b1;
               shift_d  = head[7:0];
               dc_d     = head[8];
               sda_d    = head[7];
               cs_n_d   = 1'b0;
               bitcnt_d = 3'd7;
               busy_d   = 1'b1;
               state_d  = StLow;
            end
         end
         StLow: begin
            if (phase_end) begin
               cnt_d   = '0;
               scl_d   = 1'b1;
               state_d = StHigh;
            end
         end
         StHigh: begin
            if (phase_end) begin
               cnt_d = '0;
               scl_d = 1'b0;
               if (bitcnt_q != 3'd0) begin
                  bitcnt_d = bitcnt_q - 3'd1;
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_d    = shift_q[6];
                  state_d  = StLow;
               end else begin
                  byte_done_d = 1'b1;
                  // Chain the next entry without releasing cs_n.
                  if (!empty) begin
                     pop      = 1'b1;
                     shift_d  = head[7:0];
                     dc_d     = head[8];
                     sda_d    = head[7];
                     bitcnt_d = 3'd7;
                     state_d  = StLow;
                  end else begin
                     state_d = StHold;
                  end
               end
            end
         end
         StHold: begin
            if (phase_end) begin
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               state_d = StGap;
            end
         end
         StGap: begin
            if (phase_end) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         pre_q       <= '0;
         bitcnt_q    <= '0;
         shift_q     <= '0;
         cs_n_q      <= 1'b1;
         scl_q       <= 1'b0;
         sda_q       <= 1'b0;
         dc_q        <= 1'b0;
         busy_q      <= 1'b0;
         byte_done_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pre_q       <= pre_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         cs_n_q      <= cs_n_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
         dc_q        <= dc_d;
         busy_q      <= busy_d;
         byte_done_q <= byte_done_d;
         overflow_q  <= overflow_d;
      end
   end

   assign cs_n      = cs_n_q;
   assign scl       = scl_q;
   assign sda       = sda_q;
   assign dc        = dc_q;
   assign busy      = busy_q;
   assign byte_done = byte_done_q;
   assign overflow  = overflow_q;

endmodule
